// File: rtl/prism_bds_segment_sequencer.sv
// Segment sequencer: slices byte-length segments into per-word beats with
// first/last byte lanes and sof/eof strobes for a downstream byte stuffer.
module prism_bds_segment_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int OFF_WIDTH  = $clog2(DATA_WIDTH/8),
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OFF_WIDTH-1:0]  cmd_offset,
  input  logic [LEN_WIDTH-1:0]  cmd_length,
  input  logic                  cmd_sof,
  input  logic                  cmd_eof,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  o_valid,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic [OFF_WIDTH-1:0]  o_lsbyte,
  output logic [OFF_WIDTH-1:0]  o_msbyte,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_err_zero_len,
  output logic [31:0]           o_frame_count
);

  localparam logic [LEN_WIDTH:0]   LANES   = (LEN_WIDTH+1)'(DATA_WIDTH/8);
  localparam logic [OFF_WIDTH-1:0] OFF_ONE = OFF_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;

  logic [OFF_WIDTH-1:0]  offset_r;
  logic [LEN_WIDTH:0]    remaining_r;
  logic                  sof_r;
  logic                  eof_r;
  logic                  first_r;

  logic                  o_valid_r;
  logic                  o_sof_r;
  logic                  o_eof_r;
  logic [OFF_WIDTH-1:0]  o_lsbyte_r;
  logic [OFF_WIDTH-1:0]  o_msbyte_r;
  logic [DATA_WIDTH-1:0] o_data_r;
  logic                  busy_r;
  logic                  err_zero_len_r;
  logic [31:0]           frame_count_r;

  logic [OFF_WIDTH-1:0]  lsbyte_s;
  logic [LEN_WIDTH:0]    lsbyte_ext_s;
  logic [LEN_WIDTH:0]    room_s;
  logic [LEN_WIDTH:0]    n_s;
  logic [OFF_WIDTH-1:0]  msbyte_s;
  logic                  last_s;
  logic                  hs_s;
  logic                  cmd_take_s;
  logic                  cmd_zero_s;
  logic                  load_s;
  logic                  advance_s;

  // Beat geometry for the word currently offered by the source.
  assign lsbyte_s     = first_r ? offset_r : {OFF_WIDTH{1'b0}};
  assign lsbyte_ext_s = {{(LEN_WIDTH+1-OFF_WIDTH){1'b0}}, lsbyte_s};
  assign room_s       = LANES - lsbyte_ext_s;
  assign last_s       = (remaining_r <= room_s);
  assign n_s          = last_s ? remaining_r : room_s;
  // Low lane bits of lsbyte+n-1; n never exceeds the lane count.
  assign msbyte_s     = lsbyte_s + n_s[OFF_WIDTH-1:0] - OFF_ONE;

  assign s_ready    = (state_r == RUN);
  assign hs_s       = s_valid & (state_r == RUN);
  assign cmd_ready  = (state_r == IDLE) | (hs_s & last_s & ~eof_r);
  assign cmd_take_s = cmd_valid & cmd_ready;
  assign cmd_zero_s = (cmd_length == {LEN_WIDTH{1'b0}});

  // Next-state and command-latch control.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    advance_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_take_s && !cmd_zero_s) begin
          state_s = RUN;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (hs_s) begin
          if (last_s) begin
            if (eof_r) begin
              state_s = GAP;
            end else if (cmd_take_s && !cmd_zero_s) begin
              state_s = RUN;
              load_s  = 1'b1;
            end else begin
              state_s = IDLE;
            end
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          state_s = RUN;
        end
      end
      GAP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latched command: loaded on acceptance, consumed beat by beat.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      offset_r    <= {OFF_WIDTH{1'b0}};
      remaining_r <= {(LEN_WIDTH+1){1'b0}};
      sof_r       <= 1'b0;
      eof_r       <= 1'b0;
      first_r     <= 1'b0;
    end else if (load_s) begin
      offset_r    <= cmd_offset;
      remaining_r <= {1'b0, cmd_length};
      sof_r       <= cmd_sof;
      eof_r       <= cmd_eof;
      first_r     <= 1'b1;
    end else if (advance_s) begin
      remaining_r <= remaining_r - n_s;
      first_r     <= 1'b0;
    end else begin
      remaining_r <= remaining_r;
      first_r     <= first_r;
    end
  end

  // Registered beat outputs, valid for exactly one cycle after a handshake.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      o_valid_r  <= 1'b0;
      o_sof_r    <= 1'b0;
      o_eof_r    <= 1'b0;
      o_lsbyte_r <= {OFF_WIDTH{1'b0}};
      o_msbyte_r <= {OFF_WIDTH{1'b0}};
      o_data_r   <= {DATA_WIDTH{1'b0}};
    end else if (hs_s) begin
      o_valid_r  <= 1'b1;
      o_sof_r    <= sof_r & first_r;
      o_eof_r    <= eof_r & last_s;
      o_lsbyte_r <= lsbyte_s;
      o_msbyte_r <= msbyte_s;
      o_data_r   <= s_data;
    end else begin
      o_valid_r  <= 1'b0;
      o_sof_r    <= 1'b0;
      o_eof_r    <= 1'b0;
    end
  end

  // Status: busy, sticky zero-length error, and eof-beat frame counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy_r         <= 1'b0;
      err_zero_len_r <= 1'b0;
      frame_count_r  <= 32'd0;
    end else begin
      busy_r <= (state_s != IDLE);
      if (cmd_take_s && cmd_zero_s) begin
        err_zero_len_r <= 1'b1;
      end else begin
        err_zero_len_r <= err_zero_len_r;
      end
      if (o_valid_r && o_eof_r) begin
        frame_count_r <= frame_count_r + 32'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

  assign o_valid        = o_valid_r;
  assign o_sof          = o_sof_r;
  assign o_eof          = o_eof_r;
  assign o_lsbyte       = o_lsbyte_r;
  assign o_msbyte       = o_msbyte_r;
  assign o_data         = o_data_r;
  assign o_busy         = busy_r;
  assign o_err_zero_len = err_zero_len_r;
  assign o_frame_count  = frame_count_r;

endmodule

// File: tb/tb_prism_bds_segment_sequencer.sv
// Directed bench for the segment sequencer: expected beats are derived from the
// segment arithmetic (offset/length -> lane ranges) and checked every cycle.
module tb_prism_bds_segment_sequencer;

  localparam int DW = 64;
  localparam int OW = 3;
  localparam int LW = 16;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [OW-1:0] cmd_offset = '0;
  logic [LW-1:0] cmd_length = '0;
  logic          cmd_sof = 1'b0;
  logic          cmd_eof = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          o_valid, o_sof, o_eof, o_busy, o_err_zero_len;
  logic [OW-1:0] o_lsbyte, o_msbyte;
  logic [DW-1:0] o_data;
  logic [31:0]   o_frame_count;

  prism_bds_segment_sequencer #(.DATA_WIDTH(DW), .OFF_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_offset(cmd_offset),
    .cmd_length(cmd_length), .cmd_sof(cmd_sof), .cmd_eof(cmd_eof),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof),
    .o_lsbyte(o_lsbyte), .o_msbyte(o_msbyte), .o_data(o_data),
    .o_busy(o_busy), .o_err_zero_len(o_err_zero_len), .o_frame_count(o_frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] ls;
    logic [2:0] ms;
    logic       sof;
    logic       eof;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         tmp_q[$];
  logic [DW-1:0] dq[$];
  int            total = 0;
  int            bad = 0;
  logic [31:0]   fc_model = 32'd0;
  logic          hs_prev;
  beat_t         cb;
  logic [DW-1:0] cd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Cut a segment into 8-lane beats straight from the offset/length rules.
  task automatic build_beats(input int off, input int len, input logic sof, input logic eof);
    int rem, ls, n;
    bit first;
    beat_t b;
    rem = len;
    first = 1'b1;
    tmp_q.delete();
    while (rem > 0) begin
      ls = first ? off : 0;
      n = (rem < 8 - ls) ? rem : 8 - ls;
      b.ls = 3'(ls);
      b.ms = 3'(ls + n - 1);
      b.sof = sof & first;
      b.eof = eof & (rem == n);
      tmp_q.push_back(b);
      rem -= n;
      first = 1'b0;
    end
  endtask

  task automatic send_cmd(input int off, input int len, input logic sof, input logic eof,
                          output int waited);
    cmd_offset = 3'(off);
    cmd_length = 16'(len);
    cmd_sof = sof;
    cmd_eof = eof;
    cmd_valid = 1'b1;
    waited = 0;
    build_beats(off, len, sof, eof);
    #1;
    while (!cmd_ready && waited < 64) begin
      @(negedge clock);
      #1;
      waited++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 64'd0, 64'd1);
    end else begin
      foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
    end
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while ((o_busy || exp_q.size() != 0) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 200) chk({name, "_idle_timeout"}, 64'd0, 64'd1);
    @(negedge clock);
    @(negedge clock);
  endtask

  // Source-side record: which words were actually consumed.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hs_prev <= 1'b0;
      dq.delete();
    end else begin
      hs_prev <= s_valid & s_ready;
      if (s_valid && s_ready) dq.push_back(s_data);
    end
  end

  // Per-cycle compare against the beat model.
  always @(negedge clock) begin
    if (!resetn) begin
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_busy", o_busy, 0);
      chk("rst_frame_count", o_frame_count, 0);
      chk("rst_err", o_err_zero_len, 0);
    end else begin
      chk("o_valid", o_valid, hs_prev);
      chk("frame_count", o_frame_count, fc_model);
      if (o_valid) begin
        if (exp_q.size() == 0 || dq.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          cb = exp_q.pop_front();
          cd = dq.pop_front();
          chk("o_lsbyte", o_lsbyte, cb.ls);
          chk("o_msbyte", o_msbyte, cb.ms);
          chk("o_sof", o_sof, cb.sof);
          chk("o_eof", o_eof, cb.eof);
          chk("o_data", o_data, cd);
        end
        if (o_eof) fc_model = fc_model + 32'd1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      s_data = {$urandom(), $urandom()};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [0:4] pat;
    int seen;

    // Pin the model against hand-cut beats.
    build_beats(6, 20, 1'b1, 1'b1);
    chk("model_023_count", tmp_q.size(), 4);
    chk("model_023_b0", tmp_q[0], {3'd6, 3'd7, 1'b1, 1'b0});
    chk("model_023_b1", tmp_q[1], {3'd0, 3'd7, 1'b0, 1'b0});
    chk("model_023_b2", tmp_q[2], {3'd0, 3'd7, 1'b0, 1'b0});
    chk("model_023_b3", tmp_q[3], {3'd0, 3'd1, 1'b0, 1'b1});
    build_beats(3, 5, 1'b1, 1'b1);
    chk("model_022_b0", tmp_q[0], {3'd3, 3'd7, 1'b1, 1'b1});

    repeat (3) @(negedge clock);
    #2 resetn = 1'b1;
    #1;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_s_ready", s_ready, 0);
    @(negedge clock);

    // Single beat; flush cycle then ready again.
    s_valid = 1'b1;
    send_cmd(3, 5, 1'b1, 1'b1, w);
    #1;
    chk("single_s_ready_run", s_ready, 1);
    @(negedge clock);
    #1;
    chk("single_beat_valid", o_valid, 1);
    chk("single_lsbyte", o_lsbyte, 3);
    chk("single_msbyte", o_msbyte, 7);
    chk("single_cmd_ready_gap", cmd_ready, 0);
    chk("single_busy_gap", o_busy, 1);
    @(negedge clock);
    #1;
    chk("single_flush_valid", o_valid, 0);
    chk("single_cmd_ready_after", cmd_ready, 1);
    chk("single_frame_count", o_frame_count, 1);
    wait_idle("single");

    // Multi-beat segment.
    send_cmd(6, 20, 1'b1, 1'b1, w);
    wait_idle("multi");
    chk("multi_frame_count", o_frame_count, 2);

    // Back-to-back: B accepted on A's last-beat handshake.
    send_cmd(0, 8, 1'b1, 1'b0, w);
    send_cmd(0, 8, 1'b0, 1'b1, w);
    chk("b2b_no_wait", w, 0);
    #1;
    chk("b2b_beat_a", o_valid, 1);
    @(negedge clock);
    #1;
    chk("b2b_beat_b", o_valid, 1);
    chk("b2b_beat_b_eof", o_eof, 1);
    wait_idle("b2b");
    chk("b2b_frame_count", o_frame_count, 3);

    // Source backpressure on the multi-beat segment.
    s_valid = 1'b0;
    send_cmd(6, 20, 1'b1, 1'b1, w);
    pat = 5'b10011;
    for (int i = 0; i < 5; i++) begin
      s_valid = pat[i];
      @(negedge clock);
    end
    s_valid = 1'b1;
    wait_idle("bp");
    chk("bp_frame_count", o_frame_count, 4);

    // Zero-length command is consumed without a beat.
    chk("zero_err_before", o_err_zero_len, 0);
    send_cmd(0, 0, 1'b1, 1'b1, w);
    #1;
    chk("zero_err_set", o_err_zero_len, 1);
    chk("zero_busy", o_busy, 0);
    chk("zero_cmd_ready", cmd_ready, 1);
    send_cmd(2, 4, 1'b1, 1'b1, w);
    wait_idle("zero_follow");
    chk("zero_err_sticky", o_err_zero_len, 1);
    chk("zero_frame_count", o_frame_count, 5);

    // Reset after the second beat of a multi-beat segment.
    send_cmd(6, 20, 1'b1, 1'b1, w);
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      #1;
      if (o_valid) seen++;
      if (seen < 2) @(negedge clock);
    end
    chk("rstmid_two_beats", seen, 2);
    #1 resetn = 1'b0;
    #1;
    chk("rstmid_valid", o_valid, 0);
    chk("rstmid_sof", o_sof, 0);
    chk("rstmid_eof", o_eof, 0);
    chk("rstmid_data", o_data, 0);
    chk("rstmid_lanes", {o_lsbyte, o_msbyte}, 0);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_err", o_err_zero_len, 0);
    chk("rstmid_count", o_frame_count, 0);
    exp_q.delete();
    fc_model = 32'd0;
    @(negedge clock);
    #2 resetn = 1'b1;
    #1;
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_count_after", o_frame_count, 0);
    @(negedge clock);
    send_cmd(0, 4, 1'b1, 1'b1, w);
    @(negedge clock);
    #1;
    chk("rstmid_next_sof", o_sof, 1);
    chk("rstmid_next_lanes", {o_lsbyte, o_msbyte}, {3'd0, 3'd3});
    wait_idle("rstmid_next");
    chk("rstmid_next_count", o_frame_count, 1);

    repeat (3) @(negedge clock);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prism_bds_segment_sequencer.md
PRISM_BDS_SEGMENT_SEQUENCER -- requirements
Module: prism_bds_segment_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning word width in bits; legal values are 32, 64 and 128.
REQ-002 The block SHALL have parameter OFF_WIDTH, default $clog2(DATA_WIDTH/8), meaning byte-lane index width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 16, meaning segment byte-length width.
REQ-004 The block SHALL have ports, one per line, name direction width meaning:
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  segment command offered.
- cmd_ready  out  1  segment command accepted when both high.
- cmd_offset  in  OFF_WIDTH  byte lane of the first valid byte in the first word.
- cmd_length  in  LEN_WIDTH  segment length in bytes.
- cmd_sof  in  1  segment starts a frame.
- cmd_eof  in  1  segment ends a frame.
- s_valid  in  1  source word available.
- s_ready  out  1  source word consumed when both high.
- s_data  in  DATA_WIDTH  source word.
- o_valid, o_sof, o_eof  out  1 each  beat strobes to the byte stuffer.
- o_lsbyte, o_msbyte  out  OFF_WIDTH each  first and last valid byte lane of the beat.
- o_data  out  DATA_WIDTH  beat word.
- o_busy  out  1  state not IDLE.
- o_err_zero_len  out  1  sticky flag for a zero-length command.
- o_frame_count  out  32  count of eof beats emitted, wraps.

Function
REQ-005 The FSM SHALL have the states IDLE, RUN and GAP.
REQ-006 cmd_ready SHALL be 1 in IDLE, and also in RUN during the handshake cycle of a last beat of a segment whose eof is 0; it SHALL be 0 otherwise.
REQ-007 On an accepted command with cmd_length>0, the block SHALL latch offset, remaining=cmd_length, sof and eof, set first=1, and enter RUN at that edge.
REQ-008 On an accepted command with cmd_length==0, the block SHALL consume the command, emit no beat, set o_err_zero_len, and remain in or return to IDLE.
REQ-009 s_ready SHALL equal (state==RUN), combinationally.
REQ-010 Per beat handshake, lsbyte SHALL be the latched offset when first=1 and 0 otherwise.
REQ-011 Per beat handshake, n SHALL be min(remaining, DATA_WIDTH/8 - lsbyte), msbyte SHALL be lsbyte+n-1, and remaining SHALL decrement by n, with all arithmetic in LEN_WIDTH+1 bits.
REQ-012 The outputs o_* SHALL be registered: a beat handshaked at edge m drives o_valid=1 for exactly the cycle after m, with o_data=s_data, o_sof=sof&first and o_eof=eof&(remaining==n).
REQ-013 o_valid SHALL be 0 in every cycle without a preceding handshake; the block has no downstream backpressure.
REQ-014 At the last-beat handshake, the next state SHALL be GAP if eof=1.
REQ-015 At the last-beat handshake with eof=0, the next state SHALL be RUN with the new command latched if a command is accepted in the same cycle, and IDLE otherwise.
REQ-016 GAP SHALL last exactly one cycle and then go to IDLE, so that o_valid is 0 in the cycle following every eof beat (the stuffer flush cycle).
REQ-017 o_frame_count SHALL increment by 1 in each cycle where o_valid&o_eof, wrapping from 0xFFFFFFFF to 0.
REQ-018 o_busy SHALL be 1 in RUN and GAP.
REQ-019 o_err_zero_len SHALL clear only on reset.

Reset
REQ-020 While resetn=0, asynchronously: state=IDLE, all o_* = 0, o_frame_count=0, o_err_zero_len=0, and latched command state cleared.
REQ-021 A reset asserted mid-segment SHALL abandon the segment with no eof emitted; after release the block SHALL be in IDLE with cmd_ready=1.

Verification (DATA_WIDTH=64)
REQ-022 Single beat: offset=3, len=5, sof=eof=1, s_valid=1 -> one beat with lsbyte=3, msbyte=7, sof=1, eof=1; o_valid=0 in the next cycle; cmd_ready=1 two cycles after the beat.
REQ-023 Multi-beat: offset=6, len=20 -> beats (6,7), (0,7), (0,7), (0,1); sof on beat 1 only; eof on beat 4 only; o_frame_count=1.
REQ-024 Back-to-back segments: A (offset=0, len=8, sof=1, eof=0) followed by B (offset=0, len=8, eof=1) held ready -> B accepted on A's handshake cycle, and beats appear on consecutive cycles.
REQ-025 Backpressure: s_valid toggled 1,0,0,1,1 on the REQ-023 command -> beats identical to REQ-023, and o_valid is high only after each handshake.
REQ-026 Zero length: len=0 -> no o_valid and o_err_zero_len=1; a following len=4 command is sequenced normally.
REQ-027 Reset mid-run: resetn pulsed low after beat 2 of REQ-023 -> all outputs 0 immediately; the next command starts with sof and count=0.
